// File: rtl/cc_level_sequencer.sv
// Frogger level/lives sequencer: edge-detected start/goal/hit drive the game-phase FSM.
// Optional per-level speed tick is enabled with CC_LEVEL_SEQUENCER_SPEED_TICK_EN.
module cc_level_sequencer #(
  parameter int COUNTER_LEVELS_DATAWIDTH = 5,
  parameter int LEVEL_MAX                = 5,
  parameter int LIVES_INIT               = 3,
  parameter int PAUSE_CYCLES             = 25000000,
  parameter int PAUSE_WIDTH              = 25,
  parameter int TICK_BASE                = 5000000,
  parameter int TICK_STEP                = 800000
) (
  input  logic                                CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                                CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                                CC_LEVEL_SEQUENCER_start_InHigh,
  input  logic                                CC_LEVEL_SEQUENCER_goal_InHigh,
  input  logic                                CC_LEVEL_SEQUENCER_hit_InHigh,
  output logic [COUNTER_LEVELS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_level_Out,
  output logic [1:0]                          CC_LEVEL_SEQUENCER_lives_Out,
  output logic                                CC_LEVEL_SEQUENCER_playing_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_pause_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_win_OutLow,
  output logic                                CC_LEVEL_SEQUENCER_lose_OutLow,
  output logic                                CC_LEVEL_SEQUENCER_speedTick_OutHigh
);

  localparam int W = COUNTER_LEVELS_DATAWIDTH;
  localparam logic [W-1:0]           LVL_MAX   = W'(LEVEL_MAX);
  localparam logic [W-1:0]           LVL_LAST  = W'(LEVEL_MAX - 1);
  localparam logic [1:0]             LIVES_RST = 2'(LIVES_INIT);
  localparam logic [PAUSE_WIDTH-1:0] PAUSE_LD  = PAUSE_WIDTH'(PAUSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_ADVANCE = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  state_t                 r_state, w_state_next;
  logic [W-1:0]           r_level, w_level_next;
  logic [1:0]             r_lives, w_lives_next;
  logic [PAUSE_WIDTH-1:0] r_pause_cnt, w_pause_cnt_next;
  logic                   r_start_q, r_goal_q, r_hit_q;
  logic                   r_playing, r_pause, r_win_n, r_lose_n;
  logic                   w_rise_start, w_rise_goal, w_rise_hit;

  assign w_rise_start = CC_LEVEL_SEQUENCER_start_InHigh & ~r_start_q;
  assign w_rise_goal  = CC_LEVEL_SEQUENCER_goal_InHigh  & ~r_goal_q;
  assign w_rise_hit   = CC_LEVEL_SEQUENCER_hit_InHigh   & ~r_hit_q;

  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      r_state     <= S_IDLE;
      r_level     <= '0;
      r_lives     <= LIVES_RST;
      r_pause_cnt <= '0;
      r_start_q   <= 1'b0;
      r_goal_q    <= 1'b0;
      r_hit_q     <= 1'b0;
      r_playing   <= 1'b0;
      r_pause     <= 1'b0;
      r_win_n     <= 1'b1;
      r_lose_n    <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_lives     <= w_lives_next;
      r_pause_cnt <= w_pause_cnt_next;
      r_start_q   <= CC_LEVEL_SEQUENCER_start_InHigh;
      r_goal_q    <= CC_LEVEL_SEQUENCER_goal_InHigh;
      r_hit_q     <= CC_LEVEL_SEQUENCER_hit_InHigh;
      // Phase flags are decoded from the next state so they line up with it.
      r_playing   <= (w_state_next == S_PLAY);
      r_pause     <= (w_state_next == S_ADVANCE);
      r_win_n     <= (w_state_next != S_WIN);
      r_lose_n    <= (w_state_next != S_LOSE);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_level_next     = r_level;
    w_lives_next     = r_lives;
    w_pause_cnt_next = r_pause_cnt;
    case (r_state)
      S_IDLE: begin
        w_level_next = '0;
        w_lives_next = LIVES_RST;
        if (w_rise_start) w_state_next = S_PLAY;
      end
      S_PLAY: begin
        if (w_rise_goal) begin
          if (r_level == LVL_LAST) begin
            w_level_next = LVL_MAX;
            w_state_next = S_WIN;
          end else begin
            w_level_next     = r_level + 1'b1;
            w_pause_cnt_next = PAUSE_LD;
            w_state_next     = S_ADVANCE;
          end
        end else if (w_rise_hit) begin
          if (r_lives <= 2'd1) begin
            w_lives_next = 2'd0;
            w_state_next = S_LOSE;
          end else begin
            w_lives_next = r_lives - 2'd1;
          end
        end
      end
      S_ADVANCE: begin
        if (r_pause_cnt == '0) w_state_next = S_PLAY;
        else                   w_pause_cnt_next = r_pause_cnt - 1'b1;
      end
      S_WIN: begin
        w_level_next = LVL_MAX;
        if (w_rise_start) begin
          w_state_next = S_IDLE;
          w_level_next = '0;
          w_lives_next = LIVES_RST;
        end
      end
      S_LOSE: begin
        w_lives_next = 2'd0;
        if (w_rise_start) begin
          w_state_next = S_IDLE;
          w_level_next = '0;
          w_lives_next = LIVES_RST;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_level_next     = '0;
        w_lives_next     = LIVES_RST;
        w_pause_cnt_next = '0;
      end
    endcase
  end

`ifdef CC_LEVEL_SEQUENCER_SPEED_TICK_EN
  logic [31:0] r_tick_cnt;
  logic [31:0] w_period;
  logic        r_tick;

  assign w_period = 32'(TICK_BASE) - 32'(r_level) * 32'(TICK_STEP);

  // Counting only while PLAY persists with an unchanged level restarts the period on every entry.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_state == S_PLAY && w_state_next == S_PLAY && w_level_next == r_level) begin
      if (r_tick_cnt == w_period - 32'd1) begin
        r_tick_cnt <= '0;
        r_tick     <= 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 32'd1;
        r_tick     <= 1'b0;
      end
    end else begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end
  end

  assign CC_LEVEL_SEQUENCER_speedTick_OutHigh = r_tick;
`else
  assign CC_LEVEL_SEQUENCER_speedTick_OutHigh = 1'b0;
`endif

  assign CC_LEVEL_SEQUENCER_level_Out        = r_level;
  assign CC_LEVEL_SEQUENCER_lives_Out        = r_lives;
  assign CC_LEVEL_SEQUENCER_playing_OutHigh  = r_playing;
  assign CC_LEVEL_SEQUENCER_pause_OutHigh    = r_pause;
  assign CC_LEVEL_SEQUENCER_win_OutLow       = r_win_n;
  assign CC_LEVEL_SEQUENCER_lose_OutLow      = r_lose_n;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer with short pause and tick periods.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, goal, hit;
  logic [4:0] level;
  logic [1:0] lives;
  logic       playing, pause, win_n, lose_n, speed_tick;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  cc_level_sequencer #(
    .COUNTER_LEVELS_DATAWIDTH(5),
    .LEVEL_MAX(5),
    .LIVES_INIT(3),
    .PAUSE_CYCLES(4),
    .PAUSE_WIDTH(25),
    .TICK_BASE(10),
    .TICK_STEP(1)
  ) dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50(clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow(rst_n),
    .CC_LEVEL_SEQUENCER_start_InHigh(start),
    .CC_LEVEL_SEQUENCER_goal_InHigh(goal),
    .CC_LEVEL_SEQUENCER_hit_InHigh(hit),
    .CC_LEVEL_SEQUENCER_level_Out(level),
    .CC_LEVEL_SEQUENCER_lives_Out(lives),
    .CC_LEVEL_SEQUENCER_playing_OutHigh(playing),
    .CC_LEVEL_SEQUENCER_pause_OutHigh(pause),
    .CC_LEVEL_SEQUENCER_win_OutLow(win_n),
    .CC_LEVEL_SEQUENCER_lose_OutLow(lose_n),
    .CC_LEVEL_SEQUENCER_speedTick_OutHigh(speed_tick)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // level, lives, playing, pause, win_n, lose_n in one call
  task automatic chk_all(input string tag, input int e_lvl, input int e_liv,
                         input int e_ply, input int e_pse, input int e_win, input int e_los);
    chk({tag, ".level"},   32'(level),   e_lvl);
    chk({tag, ".lives"},   32'(lives),   e_liv);
    chk({tag, ".playing"}, 32'(playing), e_ply);
    chk({tag, ".pause"},   32'(pause),   e_pse);
    chk({tag, ".win_n"},   32'(win_n),   e_win);
    chk({tag, ".lose_n"},  32'(lose_n),  e_los);
  endtask

  // goal rise from PLAY at a level below the last one: ADVANCE for 4 cycles then PLAY
  task automatic goal_advance(input int new_lvl, input int e_liv);
    goal = 1'b1; tick(); goal = 1'b0;
    chk_all("goal_adv", new_lvl, e_liv, 0, 1, 1, 1);
    tick(); tick(); tick();
    chk("adv_last.pause", 32'(pause), 1);
    tick();
    chk_all("adv_done", new_lvl, e_liv, 1, 0, 1, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; goal = 1'b0; hit = 1'b0;
    tick(); tick(); tick();
    chk_all("reset", 0, 3, 0, 0, 1, 1);
    chk("reset.tick", 32'(speed_tick), 0);
    rst_n = 1'b1; tick();
    chk_all("idle", 0, 3, 0, 0, 1, 1);
    start = 1'b1; tick();
    chk_all("start", 0, 3, 1, 0, 1, 1);
    tick(); start = 1'b0; tick();

    // goal held for 10 cycles: one event, pause for exactly 4 cycles
    goal = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.level",   32'(level),   1);
      chk("hold.pause",   32'(pause),   (i < 4) ? 1 : 0);
      chk("hold.playing", 32'(playing), (i >= 4) ? 1 : 0);
    end
    goal = 1'b0; tick();

    start = 1'b1; tick(); start = 1'b0;
    chk_all("start_in_play", 1, 3, 1, 0, 1, 1);
    tick();

    goal_advance(2, 3);
    goal_advance(3, 3);
    goal_advance(4, 3);
    goal = 1'b1; tick(); goal = 1'b0;
    chk_all("win", 5, 3, 0, 0, 0, 1);
    tick();
    goal = 1'b1; tick(); goal = 1'b0; tick();
    chk_all("win_goal", 5, 3, 0, 0, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk_all("win_restart", 0, 3, 0, 0, 1, 1);
    tick();

    // hit in PLAY, then hit during ADVANCE is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk_all("play2", 0, 3, 1, 0, 1, 1);
    hit = 1'b1; tick(); hit = 1'b0;
    chk_all("hit1", 0, 2, 1, 0, 1, 1);
    goal = 1'b1; tick(); goal = 1'b0;
    chk_all("adv_hit_pre", 1, 2, 0, 1, 1, 1);
    hit = 1'b1; tick(); hit = 1'b0;
    chk_all("adv_hit", 1, 2, 0, 1, 1, 1);
    tick(); tick();
    chk("adv_hit.pause", 32'(pause), 1);
    tick();
    chk_all("adv_hit_done", 1, 2, 1, 0, 1, 1);
    hit = 1'b1; tick(); hit = 1'b0;
    chk_all("hit2", 1, 1, 1, 0, 1, 1);
    tick();

    // simultaneous goal and hit with one life: goal wins
    goal = 1'b1; hit = 1'b1; tick(); goal = 1'b0; hit = 1'b0;
    chk_all("goal_hit", 2, 1, 0, 1, 1, 1);
    tick(); tick(); tick(); tick();
    chk_all("goal_hit_done", 2, 1, 1, 0, 1, 1);
    hit = 1'b1; tick(); hit = 1'b0;
    chk_all("lose", 2, 0, 0, 0, 1, 0);
    tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    chk_all("lose_hit", 2, 0, 0, 0, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk_all("lose_restart", 0, 3, 0, 0, 1, 1);
    tick();

    // reset during the second pause cycle
    start = 1'b1; tick(); start = 1'b0; tick();
    goal = 1'b1; tick(); goal = 1'b0;
    chk_all("pause1", 1, 3, 0, 1, 1, 1);
    tick();
    chk("pause2.pause", 32'(pause), 1);
    rst_n = 1'b0; tick();
    chk_all("mid_reset", 0, 3, 0, 0, 1, 1);
    rst_n = 1'b1; tick();
    chk_all("post_reset", 0, 3, 0, 0, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk_all("replay", 0, 3, 1, 0, 1, 1);

`ifdef CC_LEVEL_SEQUENCER_SPEED_TICK_EN
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("tick_l0", 32'(speed_tick), (k % 10 == 0) ? 1 : 0);
    end
    goal_advance(1, 3);
    goal_advance(2, 3);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("tick_l2", 32'(speed_tick), (k % 8 == 0) ? 1 : 0);
    end
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("tick_off", 32'(speed_tick), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cc_level_sequencer.md
Name: cc_level_sequencer

Overview:
Level/lives sequencer for the Frogger game. It is the producer side of the level-count interface. It holds the current level value that the downstream level comparator checks against the winning level, advances the level when the frog reaches the goal, and tracks lives on collisions. It also generates the game-phase outputs (playing, inter-level pause, win, lose) used by the draw and car-control logic.

Parameters:
COUNTER_LEVELS_DATAWIDTH, 5, width of level output; must hold LEVEL_MAX
LEVEL_MAX, 5, winning level value (downstream comparator flags win at this value)
LIVES_INIT, 3, lives loaded at game start, range 1..3
PAUSE_CYCLES, 25000000, length of the inter-level pause in clock cycles, must be >= 2
PAUSE_WIDTH, 25, width of the pause counter
TICK_BASE, 5000000, speed-tick period at level 0 (optional feature only)
TICK_STEP, 800000, period reduction per level (optional feature only); TICK_BASE - LEVEL_MAX*TICK_STEP must be >= 2

Ports:
CC_LEVEL_SEQUENCER_CLOCK_50  in  1  system clock, 50 MHz
CC_LEVEL_SEQUENCER_RESET_InLow  in  1  synchronous active-low reset
CC_LEVEL_SEQUENCER_start_InHigh  in  1  start/restart request, level signal, rising edge used
CC_LEVEL_SEQUENCER_goal_InHigh  in  1  frog reached top row, level signal, rising edge used
CC_LEVEL_SEQUENCER_hit_InHigh  in  1  frog collided with car, level signal, rising edge used
CC_LEVEL_SEQUENCER_level_Out  out  COUNTER_LEVELS_DATAWIDTH  current level, 0..LEVEL_MAX
CC_LEVEL_SEQUENCER_lives_Out  out  2  remaining lives
CC_LEVEL_SEQUENCER_playing_OutHigh  out  1  high in PLAY only
CC_LEVEL_SEQUENCER_pause_OutHigh  out  1  high in ADVANCE only
CC_LEVEL_SEQUENCER_win_OutLow  out  1  low in WIN
CC_LEVEL_SEQUENCER_lose_OutLow  out  1  low in LOSE
CC_LEVEL_SEQUENCER_speedTick_OutHigh  out  1  per-level speed pulse (optional feature)

Behaviour:
- One clock. Reset is synchronous and active-low: sampled on the clock's rising edge while RESET_InLow=0.
- Reset values:
  - state=IDLE, level=0, lives=LIVES_INIT.
  - playing=0, pause=0, win_OutLow=1, lose_OutLow=1, speedTick=0.
  - Pause counter=0.
  - Edge registers start_q, goal_q and hit_q all =0.
- Edge detection: rise_x = x & ~x_q, where x_q is x registered every cycle.
  - An input held high produces exactly one event.
  - The event acts at the same clock edge where x is first sampled high. Registered outputs change on that edge, so latency is 1 cycle from input change.
- All outputs are registered. No combinational path from input to output.
- FSM:
  - IDLE: level=0, lives=LIVES_INIT. On rise_start -> PLAY.
  - PLAY, on rise_goal:
    - If level==LEVEL_MAX-1: level<=LEVEL_MAX, go to WIN.
    - Otherwise: level<=level+1, pause counter<=PAUSE_CYCLES-1, go to ADVANCE.
  - PLAY, on rise_hit (no rise_goal the same cycle):
    - If lives==1: lives<=0, go to LOSE.
    - Otherwise: lives<=lives-1, stay in PLAY.
  - PLAY, rise_goal and rise_hit in the same cycle: goal wins and the hit is discarded.
  - ADVANCE: counter decrements each cycle. When counter==0 -> PLAY, so pause is high for exactly PAUSE_CYCLES cycles. goal, hit and start events are ignored (edge registers still update).
  - WIN: level holds LEVEL_MAX, win_OutLow=0. On rise_start -> IDLE.
  - LOSE: level holds its value, lives=0, lose_OutLow=0. On rise_start -> IDLE.
- Level never exceeds LEVEL_MAX and never wraps.
- Lives never decrement below 0.
- start is ignored in PLAY and ADVANCE.
- Reset asserted in any state returns everything to reset values on the next clock edge, including a partial pause count.
- Illegal state encodings go to IDLE.

Optional Feature:
CC_LEVEL_SEQUENCER_SPEED_TICK_EN
- Defined:
  - A tick counter runs only in PLAY, with period P = TICK_BASE - level*TICK_STEP.
  - speedTick pulses high for 1 cycle each time the counter reaches P-1, then the counter restarts at 0.
  - The counter clears to 0 on reset, on any level change, and in every non-PLAY state.
  - The first tick comes P cycles after entering PLAY.
- Not defined: the tick logic is absent and speedTick is tied to 0. The port stays, so instantiations are identical either way.

Test Plan:
Bench overrides: PAUSE_CYCLES=4, LEVEL_MAX=5, LIVES_INIT=3, TICK_BASE=10, TICK_STEP=1.
1. Reset held 3 cycles, then released -> level=0, lives=3, playing=0, win_OutLow=1, lose_OutLow=1. start pulse -> playing=1 on the next edge.
2. In PLAY, goal held high 10 cycles -> level=1 exactly once. pause=1 for exactly 4 cycles, then playing=1.
3. Five separate goal rises, each after the pause ends -> level steps 1,2,3,4,5. After the fifth, win_OutLow=0 and playing=0. A further goal rise leaves level=5. A start rise -> IDLE with level=0.
4. Three hit rises in PLAY -> lives 2,1,0. After the third, lose_OutLow=0. A hit during ADVANCE leaves lives unchanged.
5. goal and hit rise in the same cycle with lives=1 -> level+1, lives stays 1, state ADVANCE (not LOSE).
6. Reset asserted on the 2nd pause cycle -> next edge gives level=0, pause=0, IDLE. With CC_LEVEL_SEQUENCER_SPEED_TICK_EN defined: at level 0, ticks every 10 cycles; at level 2, ticks every 8 cycles.
